aes_round_sequencer: RTL and testbench

//  Iterative AES-128 controller. Shares one external round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey

---
 rtl/aes_round_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller.
// Two requesters share one external round core. Requests are arbitrated
// round-robin. The controller applies the initial whitening, then steps
// NUM_ROUNDS rounds through the core. The result is held on a valid/ready
// port until the consumer takes it.
module aes_round_sequencer #(
  parameter int ROUND_LAT  = 1,
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         req1_ready,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic [3:0]   rnd_rc,
  output logic         rnd_last,
  output logic         rnd_en,
  input  logic [127:0] rnd_state_nxt,
  input  logic [127:0] rnd_key_nxt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] out_key_last,
  output logic         out_id,
  output logic         busy
);

  localparam logic [3:0] LAT_LAST = 4'(ROUND_LAT - 1);
  localparam logic [3:0] RC_LAST  = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_s;
  logic [127:0] st_r;
  logic [127:0] key_r;
  logic [3:0]   rc_r;
  logic [3:0]   wait_cnt_r;
  logic         id_r;
  logic         last_grant_r;
  logic         grant_s;
  logic         accept_s;
  logic         step_s;

  // Next-state decode, round-robin grant and control outputs
  always_comb begin
    state_s    = state_r;
    grant_s    = 1'b0;
    accept_s   = 1'b0;
    step_s     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rnd_en     = 1'b0;
    rnd_rc     = 4'd0;
    rnd_last   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // On a tie the requester that did not win last time is served
        if (req0_valid && req1_valid) begin
          grant_s = ~last_grant_r;
        end else if (req1_valid) begin
          grant_s = 1'b1;
        end else begin
          grant_s = 1'b0;
        end
        // No grant is shown while reset is asserted, so nothing looks accepted
        if (rst_n && (req0_valid || req1_valid)) begin
          accept_s   = 1'b1;
          req0_ready = ~grant_s;
          req1_ready = grant_s;
          state_s    = ST_ROUND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ROUND: begin
        busy     = 1'b1;
        rnd_en   = 1'b1;
        rnd_rc   = rc_r;
        rnd_last = (rc_r == RC_LAST);
        if (wait_cnt_r == LAT_LAST) begin
          step_s = 1'b1;
          if (rc_r == RC_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ROUND;
          end
        end else begin
          state_s = ST_ROUND;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Block state, round key, owner id and arbitration history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_r         <= 128'd0;
      key_r        <= 128'd0;
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      st_r         <= grant_s ? (req1_data ^ req1_key) : (req0_data ^ req0_key);
      key_r        <= grant_s ? req1_key : req0_key;
      id_r         <= grant_s;
      last_grant_r <= grant_s;
    end else if (step_s) begin
      st_r  <= rnd_state_nxt;
      key_r <= rnd_key_nxt;
    end else begin
      st_r         <= st_r;
      key_r        <= key_r;
      id_r         <= id_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Round index and core-latency counter; neither wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc_r       <= 4'd0;
      wait_cnt_r <= 4'd0;
    end else if (accept_s) begin
      rc_r       <= 4'd0;
      wait_cnt_r <= 4'd0;
    end else if (step_s) begin
      wait_cnt_r <= 4'd0;
      if (rc_r != RC_LAST) begin
        rc_r <= rc_r + 4'd1;
      end else begin
        rc_r <= rc_r;
      end
    end else if (state_r == ST_ROUND) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      rc_r       <= rc_r;
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign rnd_state    = st_r;
  assign rnd_key      = key_r;
  assign out_data     = st_r;
  assign out_key_last = key_r;
  assign out_id       = id_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer. A behavioural AES round core is
// attached to each instance: u_dut (ROUND_LAT=1) and u_dut3 (ROUND_LAT=3).
// The core on u_dut3 returns corrupted results until its inputs have been
// held for three cycles.
module tb_aes_round_sequencer;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [127:0] req0_data = 128'd0, req0_key = 128'd0;
  logic [127:0] req1_data = 128'd0, req1_key = 128'd0;
  logic         req0_ready, req1_ready;
  logic [127:0] rnd_state, rnd_key, rnd_state_nxt, rnd_key_nxt;
  logic [3:0]   rnd_rc;
  logic         rnd_last, rnd_en;
  logic         out_valid, out_id, busy;
  logic         out_ready = 1'b1;
  logic [127:0] out_data, out_key_last;

  logic         l3_req0_valid = 1'b0, l3_req1_valid = 1'b0;
  logic [127:0] l3_req0_data = 128'd0, l3_req0_key = 128'd0;
  logic [127:0] l3_req1_data = 128'd0, l3_req1_key = 128'd0;
  logic         l3_req0_ready, l3_req1_ready;
  logic [127:0] l3_rnd_state, l3_rnd_key, l3_rnd_state_nxt, l3_rnd_key_nxt;
  logic [3:0]   l3_rnd_rc;
  logic         l3_rnd_last, l3_rnd_en;
  logic         l3_out_valid, l3_out_id, l3_busy;
  logic         l3_out_ready = 1'b1;
  logic [127:0] l3_out_data, l3_out_key_last;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KL  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KL   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  function automatic logic [7:0] sb(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] rc);
    logic [7:0]  rcon;
    logic [31:0] t, n0, n1, n2, n3;
    case (rc)
      4'd0: rcon = 8'h01;  4'd1: rcon = 8'h02;  4'd2: rcon = 8'h04;  4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;  4'd5: rcon = 8'h20;  4'd6: rcon = 8'h40;  4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;  4'd9: rcon = 8'h36;  default: rcon = 8'h00;
    endcase
    t  = {sb(k[23:16]), sb(k[15:8]), sb(k[7:0]), sb(k[31:24])} ^ {rcon, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic [3:0] rc, input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   s0, s1, s2, s3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb(s[127 - 8 * i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) b[c * 4 + rw] = a[((c + rw) % 4) * 4 + rw];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        s0 = b[c * 4]; s1 = b[c * 4 + 1]; s2 = b[c * 4 + 2]; s3 = b[c * 4 + 3];
        b[c * 4]     = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
        b[c * 4 + 1] = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
        b[c * 4 + 2] = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
        b[c * 4 + 3] = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
      end
    end
    for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = b[i];
    return r ^ key_step(k, rc);
  endfunction

  // Full reference encryption: returns {ciphertext, final round key}
  function automatic logic [255:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k;
    s = pt ^ key;
    k = key;
    for (int r = 0; r < 10; r++) begin
      s = round_fn(s, k, 4'(r), (r == 9));
      k = key_step(k, 4'(r));
    end
    return {s, k};
  endfunction

  // Single-cycle core for the ROUND_LAT=1 instance
  assign rnd_state_nxt = round_fn(rnd_state, rnd_key, rnd_rc, rnd_last);
  assign rnd_key_nxt   = key_step(rnd_key, rnd_rc);

  // Three-cycle core: counts how long the current inputs have been held
  logic [260:0] l3_prev = 261'd0;
  int           l3_held = 0;
  always @(negedge clk) begin
    if (l3_rnd_en && l3_prev[260] &&
        (l3_prev[259:0] == {l3_rnd_rc, l3_rnd_state, l3_rnd_key})) l3_held <= l3_held + 1;
    else l3_held <= 1;
    l3_prev <= {l3_rnd_en, l3_rnd_rc, l3_rnd_state, l3_rnd_key};
  end
  assign l3_rnd_state_nxt = (l3_held >= 3) ? round_fn(l3_rnd_state, l3_rnd_key, l3_rnd_rc, l3_rnd_last)
                                           : ~round_fn(l3_rnd_state, l3_rnd_key, l3_rnd_rc, l3_rnd_last);
  assign l3_rnd_key_nxt   = (l3_held >= 3) ? key_step(l3_rnd_key, l3_rnd_rc)
                                           : ~key_step(l3_rnd_key, l3_rnd_rc);

  aes_round_sequencer #(.ROUND_LAT(1), .NUM_ROUNDS(10)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_key(req0_key), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_key(req1_key), .req1_ready(req1_ready),
    .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_rc(rnd_rc), .rnd_last(rnd_last), .rnd_en(rnd_en),
    .rnd_state_nxt(rnd_state_nxt), .rnd_key_nxt(rnd_key_nxt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_key_last(out_key_last), .out_id(out_id), .busy(busy));

  aes_round_sequencer #(.ROUND_LAT(3), .NUM_ROUNDS(10)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(l3_req0_valid), .req0_data(l3_req0_data), .req0_key(l3_req0_key), .req0_ready(l3_req0_ready),
    .req1_valid(l3_req1_valid), .req1_data(l3_req1_data), .req1_key(l3_req1_key), .req1_ready(l3_req1_ready),
    .rnd_state(l3_rnd_state), .rnd_key(l3_rnd_key), .rnd_rc(l3_rnd_rc), .rnd_last(l3_rnd_last),
    .rnd_en(l3_rnd_en), .rnd_state_nxt(l3_rnd_state_nxt), .rnd_key_nxt(l3_rnd_key_nxt),
    .out_valid(l3_out_valid), .out_ready(l3_out_ready), .out_data(l3_out_data),
    .out_key_last(l3_out_key_last), .out_id(l3_out_id), .busy(l3_busy));

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_rnd_en"}, rnd_en, 1'b0);
    chk1({tag, "_rnd_last"}, rnd_last, 1'b0);
    chk4({tag, "_rnd_rc"}, rnd_rc, 4'd0);
    chk1({tag, "_out_id"}, out_id, 1'b0);
    chk1({tag, "_req0_ready"}, req0_ready, 1'b0);
    chk1({tag, "_req1_ready"}, req1_ready, 1'b0);
    chk128({tag, "_rnd_state"}, rnd_state, 128'd0);
    chk128({tag, "_rnd_key"}, rnd_key, 128'd0);
    chk128({tag, "_out_data"}, out_data, 128'd0);
    chk128({tag, "_out_key_last"}, out_key_last, 128'd0);
  endtask

  // Call right after a posedge; returns just after the accepting edge
  task automatic wait_accept(input string tag, output logic who);
    logic ok;
    ok  = 1'b0;
    who = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        ok  = 1'b1;
        who = req1_ready;
        chk1({tag, "_ready_onehot"}, req0_ready & req1_ready, 1'b0);
        break;
      end
    end
    chk1({tag, "_accept_seen"}, ok, 1'b1);
    step();
  endtask

  // Call just after the accepting edge; returns at the negedge of the first DONE cycle
  task automatic wait_result(input string tag, input logic id_exp,
                             input logic [127:0] d_exp, input logic [127:0] k_exp);
    int   cyc;
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      chk4({tag, "_rnd_rc"}, rnd_rc, 4'(cyc));
      chk1({tag, "_rnd_last"}, rnd_last, (cyc == 9));
      chk1({tag, "_rnd_en"}, rnd_en, 1'b1);
      chk1({tag, "_busy_round"}, busy, 1'b1);
      chk1({tag, "_ready_round"}, req0_ready | req1_ready, 1'b0);
      @(posedge clk);
      cyc++;
    end
    chk1({tag, "_out_valid_seen"}, seen, 1'b1);
    chk128({tag, "_latency"}, 128'(cyc), 128'd10);
    chk1({tag, "_out_id"}, out_id, id_exp);
    chk128({tag, "_out_data"}, out_data, d_exp);
    chk128({tag, "_out_key_last"}, out_key_last, k_exp);
    chk1({tag, "_rnd_en_done"}, rnd_en, 1'b0);
    chk1({tag, "_rnd_last_done"}, rnd_last, 1'b0);
    chk4({tag, "_rnd_rc_done"}, rnd_rc, 4'd0);
    chk1({tag, "_ready_done"}, req0_ready | req1_ready, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : main
    logic         who;
    logic [255:0] res;
    logic [127:0] cur_pt, cur_key;
    logic [127:0] p0_pt [3];
    logic [127:0] p0_key [3];
    logic [127:0] p1_pt [2];
    logic [127:0] p1_key [2];
    int           n0, n1, cyc;
    logic         found, stale;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset");
    step();

    // FIPS-197 C.1 on requester 0
    req0_valid = 1'b1; req0_data = C1_PT; req0_key = C1_KEY;
    wait_accept("t1", who);
    chk1("t1_grant", who, 1'b0);
    req0_valid = 1'b0;
    wait_result("t1", 1'b0, C1_CT, C1_KL);
    step();
    @(negedge clk);
    chk1("t1_idle_busy", busy, 1'b0);
    chk1("t1_idle_valid", out_valid, 1'b0);
    step();

    // Both requesters valid from reset: round-robin 0,1,0,1,0
    p0_pt[0] = C1_PT;                               p0_key[0] = C1_KEY;
    p0_pt[1] = 128'hdeadbeef0123456789abcdeffedcba98; p0_key[1] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    p0_pt[2] = 128'hffffffffffffffffffffffffffffffff; p0_key[2] = 128'h00000000000000000000000000000000;
    p1_pt[0] = B_PT;                                p1_key[0] = B_KEY;
    p1_pt[1] = 128'h00000000000000000000000000000001; p1_key[1] = 128'hffffffffffffffffffffffffffffffff;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = p0_pt[0]; req0_key = p0_key[0];
    req1_valid = 1'b1; req1_data = p1_pt[0]; req1_key = p1_key[0];
    @(negedge clk);
    chk1("t2_ready_in_reset", req0_ready | req1_ready, 1'b0);
    step();
    rst_n = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept("t2", who);
      chk1("t2_grant", who, 1'((k % 2) == 1));
      cur_pt  = 128'd0;
      cur_key = 128'd0;
      if (!who && n0 < 3) begin
        cur_pt = p0_pt[n0]; cur_key = p0_key[n0]; n0++;
        if (n0 < 3) begin req0_data = p0_pt[n0]; req0_key = p0_key[n0]; end
        else req0_valid = 1'b0;
      end else if (who && n1 < 2) begin
        cur_pt = p1_pt[n1]; cur_key = p1_key[n1]; n1++;
        if (n1 < 2) begin req1_data = p1_pt[n1]; req1_key = p1_key[n1]; end
        else req1_valid = 1'b0;
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      res = aes128(cur_pt, cur_key);
      wait_result("t2", 1'((k % 2) == 1), res[255:128], res[127:0]);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure: hold the result for 20 cycles while requester 1 waits
    out_ready  = 1'b0;
    req0_valid = 1'b1; req0_data = B_PT; req0_key = B_KEY;
    wait_accept("t3", who);
    chk1("t3_grant", who, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = p0_pt[1]; req1_key = p1_key[0];
    wait_result("t3", 1'b0, B_CT, B_KL);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk1("t3_hold_valid", out_valid, 1'b1);
      chk128("t3_hold_data", out_data, B_CT);
      chk1("t3_hold_id", out_id, 1'b0);
      chk1("t3_hold_ready", req0_ready | req1_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk1("t3_release_valid", out_valid, 1'b0);
    chk1("t3_release_busy", busy, 1'b0);
    chk1("t3_release_req1_ready", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    res = aes128(p0_pt[1], p1_key[0]);
    wait_result("t3b", 1'b1, res[255:128], res[127:0]);
    step();

    // Reset in the middle of round 5
    req0_valid = 1'b1; req0_data = p0_pt[1]; req0_key = p0_key[1];
    wait_accept("t5", who);
    req0_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rnd_rc == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    chk1("t5_reached_rc5", found, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("t5");
    stale = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk1("t5_no_stale_valid", stale, 1'b0);
    step();
    req1_valid = 1'b1; req1_data = C1_PT; req1_key = C1_KEY;
    wait_accept("t5b", who);
    chk1("t5b_grant", who, 1'b1);
    req1_valid = 1'b0;
    wait_result("t5b", 1'b1, C1_CT, C1_KL);
    step();

    // ROUND_LAT=3 instance: each rc held three cycles, result after 30 cycles
    l3_req0_valid = 1'b1; l3_req0_data = C1_PT; l3_req0_key = C1_KEY;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (l3_req0_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk1("t4_accept_seen", found, 1'b1);
    step();
    l3_req0_valid = 1'b0;
    cyc   = 0;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (l3_out_valid) begin
        found = 1'b1;
        break;
      end
      chk4("t4_rnd_rc", l3_rnd_rc, 4'(cyc / 3));
      chk1("t4_rnd_last", l3_rnd_last, (cyc / 3 == 9));
      chk1("t4_rnd_en", l3_rnd_en, 1'b1);
      @(posedge clk);
      cyc++;
    end
    chk1("t4_out_valid_seen", found, 1'b1);
    chk128("t4_latency", 128'(cyc), 128'd30);
    chk128("t4_out_data", l3_out_data, C1_CT);
    chk128("t4_out_key_last", l3_out_key_last, C1_KL);
    chk1("t4_out_id", l3_out_id, 1'b0);
    chk1("t4_rnd_en_done", l3_rnd_en, 1'b0);
    step();
    @(negedge clk);
    chk1("t4_idle_busy", l3_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
